// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM lane mux/demux pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdm_pkg;

   // Framing state of the receive-side demux
   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      COLLECT = 2'd1,
      ALIGNED = 2'd2
   } tdm_state_t;

   // Width of a slot index for a frame of n slots (at least one bit)
   function automatic int slot_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Bit offset of lane k in a packed bus of lanes each w bits wide
   function automatic int lane_lo(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/tdm_demux.sv
// TDM demux: spreads one-slot-per-beat frames onto NUM_CH parallel lanes, frame-coherent.
// Latency: out_data/out_valid one cycle after the edge accepting the last slot beat.
// Backpressure: none; always ready, idle (in_valid=0) cycles change nothing.
module tdm_demux
   import tdm_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int DATA_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   input  logic                       in_sof,
   input  logic [DATA_W-1:0]          in_data,
   output logic [NUM_CH*DATA_W-1:0]   out_data,
   output logic                       out_valid,
   output logic                       out_err,
   output logic                       out_locked
);

   localparam int SW = slot_w(NUM_CH);
   localparam int BW = NUM_CH * DATA_W;

   tdm_state_t          state_q, state_d;
   logic [SW-1:0]       slot_q, slot_d;
   logic [BW-1:0]       shadow_q, shadow_d;
   logic [BW-1:0]       out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic                out_err_q, out_err_d;

   // Next-state: framing FSM, shadow fill, and whole-frame publication
   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      shadow_d    = shadow_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      out_err_d   = 1'b0;

      if (in_valid) begin
         case (state_q)
            HUNT: begin
               // Non-SOF beats are dropped silently until a frame start shows up
               if (in_sof) begin
                  shadow_d[lane_lo(0, DATA_W) +: DATA_W] = in_data;
                  slot_d  = SW'(1);
                  state_d = COLLECT;
               end
            end
            COLLECT: begin
               if (in_sof) begin
                  // Short frame: drop it and restart on this SOF beat
                  out_err_d = 1'b1;
                  shadow_d[lane_lo(0, DATA_W) +: DATA_W] = in_data;
                  slot_d    = SW'(1);
               end else begin
                  for (int k = 0; k < NUM_CH; k++) begin
                     if (slot_q == SW'(k)) begin
                        shadow_d[lane_lo(k, DATA_W) +: DATA_W] = in_data;
                     end
                  end
                  if (slot_q == SW'(NUM_CH - 1)) begin
                     // Publish including the beat being merged this cycle
                     out_data_d  = shadow_d;
                     out_valid_d = 1'b1;
                     slot_d      = '0;
                     state_d     = ALIGNED;
                  end else begin
                     slot_d = slot_q + SW'(1);
                  end
               end
            end
            ALIGNED: begin
               if (in_sof) begin
                  shadow_d[lane_lo(0, DATA_W) +: DATA_W] = in_data;
                  slot_d  = SW'(1);
                  state_d = COLLECT;
               end else begin
                  // Long frame: lose lock and hunt for the next SOF
                  out_err_d = 1'b1;
                  state_d   = HUNT;
               end
            end
            default: begin
               state_d = HUNT;
               slot_d  = '0;
            end
         endcase
      end
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         slot_q      <= '0;
         shadow_q    <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         shadow_q    <= shadow_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_err_q   <= out_err_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign out_err    = out_err_q;
   assign out_locked = (state_q == COLLECT) || (state_q == ALIGNED);

endmodule

// File: doc/tdm_demux.md
Name: tdm_demux

Overview:
- Receive-side counterpart of the team's lane muxes. Takes a time-division-multiplexed stream (one slot per beat, frame start marked by in_sof) and redistributes each slot onto its own parallel output lane.
- Publishes a complete, coherent frame on all lanes at once with a one-cycle valid strobe.
- Sits at the far end of a serial/TDM link, in front of per-channel consumers.

Parameters:
- NUM_CH, 4, slots per frame / number of output lanes; legal range 2..16.
- DATA_W, 8, width of one slot and of each output lane in bits.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies in_data/in_sof this cycle; no backpressure, block is always ready.
- in_sof  input  1  high on the beat carrying slot 0 of a frame.
- in_data  input  DATA_W  slot payload.
- out_data  output  NUM_CH*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W]; registered.
- out_valid  output  1  one-cycle pulse: out_data just updated with a complete frame.
- out_err  output  1  one-cycle pulse: framing error detected.
- out_locked  output  1  high while in ALIGNED or COLLECT.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_data=0, out_valid=0, out_err=0, out_locked=0.
  - Shadow buffer=0, slot counter=0, state=HUNT.
- Shadow buffer: NUM_CH x DATA_W registers filled slot by slot. out_data is loaded from the completed shadow in one step, so it never shows a mixed-frame state.
- Slot counter: width $clog2(NUM_CH); indexes the next shadow slot; reset to 0.
- A beat is a cycle with in_valid=1. Cycles with in_valid=0 change nothing, and any number of idle cycles may occur mid-frame.
- HUNT (unlocked):
  - Beat with in_sof=0: discarded, no error.
  - Beat with in_sof=1: shadow[0]<=in_data, slot<=1, go to COLLECT.
- COLLECT:
  - Beat with in_sof=0: shadow[slot]<=in_data.
    - If slot==NUM_CH-1: out_data<=shadow with this beat merged in, out_valid=1 next cycle, slot<=0, go to ALIGNED.
    - Otherwise: slot<=slot+1.
  - Beat with in_sof=1 (early SOF, short frame): out_err=1 next cycle; partial frame discarded, out_data unchanged; shadow[0]<=in_data, slot<=1, stay in COLLECT.
- ALIGNED (frame boundary expected):
  - Beat with in_sof=1: shadow[0]<=in_data, slot<=1, go to COLLECT.
  - Beat with in_sof=0 (missing SOF, long frame): out_err=1 next cycle, beat discarded, go to HUNT.
- Latency: out_valid and new out_data appear exactly 1 cycle after the clock edge that accepts the last slot beat. out_data holds until the next completed frame.
- Back-to-back frames with no idle cycles sustain 1 frame per NUM_CH cycles.
- out_valid and out_err are never asserted in the same cycle.
- Reset asserted mid-frame: all state cleared immediately, partial frame lost, no out_valid or out_err generated.
- Shadow slots not yet rewritten in a new frame are always overwritten before publication, so stale data never escapes.

Decomposition:
- Shared package tdm_pkg holds:
  - state enum {HUNT, COLLECT, ALIGNED} in 2 bits.
  - Function for slot index width, clog2 of NUM_CH.
  - Lane-slice helper (k*DATA_W offset) reused by the matching TDM mux.
- No sub-module is natural. Shadow register, counter and FSM stay in one module of roughly 150 lines.

Test Plan:
- Nominal frame, NUM_CH=4: beats 0x11(sof),0x22,0x33,0x44 → one cycle later out_valid=1 and out_data=0x44332211, out_locked=1; out_data holds after out_valid drops.
- Idle gaps: same frame with 3 in_valid=0 cycles between each beat → identical out_data, out_valid exactly once, 1 cycle after 0x44 is accepted.
- Early SOF: 0xA1(sof),0xA2, then 0xB1(sof),0xB2,0xB3,0xB4 → out_err pulse 1 cycle after 0xB1; then out_valid with out_data=0xB4B3B2B1; previous out_data unchanged until then.
- Missing SOF: complete frame, then beat 0x55 with sof=0 → out_err pulse, out_locked=0; following non-sof beats 0x66,0x77 → ignored, no further errors; next sof beat relocks.
- Back-to-back: 3 consecutive frames with no idle cycles → out_valid pulses at cycles 4, 8, 12 after the first beat, each with the correct lane data.
- Reset mid-frame: rst_n low after 2 beats → all outputs 0 asynchronously; after release, 2 non-sof beats are ignored and a fresh 4-beat frame publishes correctly.
